// File: rtl/multibyte_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multibyte_add_seq_pkg
// Brief    : Shared FSM state encoding and byte-width constant for the
//            byte-serial multi-byte adder.
// Revision : 1.0 - initial release
// ============================================================================
package multibyte_add_seq_pkg;

    localparam int c_byte_w = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : multibyte_add_seq_pkg
`default_nettype wire

// File: rtl/multibyte_add_seq_byte_add.sv
`default_nettype none
// ============================================================================
// Module   : byte_add
// Brief    : Combinational 8-bit ripple-carry adder with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
module byte_add
    import multibyte_add_seq_pkg::*;
(
    input  logic [c_byte_w-1:0] a,
    input  logic [c_byte_w-1:0] b,
    input  logic                cin,
    output logic [c_byte_w-1:0] sum,
    output logic                cout
);

    logic [c_byte_w:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < c_byte_w; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[c_byte_w];

endmodule : byte_add
`default_nettype wire

// File: rtl/multibyte_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : multibyte_add_seq
// Brief    : Byte-serial unsigned adder; one shared 8-bit adder processes one
//            operand byte per cycle, result held under consumer backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [c_byte_w*NBYTES-1:0]   a,
    input  logic [c_byte_w*NBYTES-1:0]   b,
    input  logic                         cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [c_byte_w*NBYTES-1:0]   sum,
    output logic                         cout,
    output logic                         parity,
    output logic                         busy
);

    localparam int                 c_idx_w    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int                 c_w        = c_byte_w * NBYTES;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NBYTES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_w-1:0]       r_a;
    logic [c_w-1:0]       r_b;
    logic [c_w-1:0]       r_sum;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_carry;
    logic                 r_cout;
    logic [c_byte_w-1:0]  w_byte_sum;
    logic                 w_byte_cout;
    logic                 w_accept;
    logic                 w_last;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == c_last_idx);

    byte_add u_byte_add (
        .a    (r_a[r_idx*c_byte_w +: c_byte_w]),
        .b    (r_b[r_idx*c_byte_w +: c_byte_w]),
        .cin  (r_carry),
        .sum  (w_byte_sum),
        .cout (w_byte_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Index parks on the last byte after RUN; it is cleared on the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum[r_idx*c_byte_w +: c_byte_w] <= w_byte_sum;
            r_carry                           <= w_byte_cout;
            if (w_last) begin
                r_cout <= w_byte_cout;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign sum    = r_sum;
    assign cout   = r_cout;
    assign parity = ^r_sum;

endmodule : multibyte_add_seq
`default_nettype wire

// File: tb/tb_multibyte_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multibyte_add_seq
// Brief    : Self-checking bench for multibyte_add_seq against an arithmetic
//            reference model (a + b + cin over 8*NBYTES bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multibyte_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         parity;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .parity    (parity),
        .busy      (busy)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set, scramble the inputs after the accept edge and
    // return how many edges later out_valid rose (-1 if it never did).
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          output int lat);
        a = x; b = y; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = -1;
        for (int k = 1; k <= 50 && lat < 0; k++) begin
            tick();
            if (out_valid) lat = k;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (sum !== '0) begin n_err++; $display("FAIL rst_sum: got %h want 0", sum); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b want 0", cout); end
        n_vec++; if (parity !== 1'b0) begin n_err++; $display("FAIL rst_parity: got %b want 0", parity); end
        rst = 1'b0;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] exp;
        int         lat;
        exp = ref_add(x, y, c);
        run_op(x, y, c, lat);
        n_vec++; if (lat != NB) begin n_err++; $display("FAIL dir_latency: got %0d want %0d", lat, NB); end
        n_vec++; if (sum !== exp[W-1:0]) begin n_err++; $display("FAIL dir_sum: got %h want %h", sum, exp[W-1:0]); end
        n_vec++; if (cout !== exp[W]) begin n_err++; $display("FAIL dir_cout: got %b want %b", cout, exp[W]); end
        n_vec++; if (parity !== ^exp[W-1:0]) begin n_err++; $display("FAIL dir_parity: got %b want %b", parity, ^exp[W-1:0]); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL dir_done_in_ready: got %b want 0", in_ready); end
        drain();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin n_err++; $display("FAIL dir_after_drain: got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
        n_vec++; if (sum !== exp[W-1:0] || cout !== exp[W])
            begin n_err++; $display("FAIL dir_hold_after_drain: got %h/%b want %h/%b", sum, cout, exp[W-1:0], exp[W]); end
    endtask

    task automatic test_backpressure();
        logic [W:0] exp;
        int         lat;
        exp = ref_add(32'h1234_5678, 32'h1111_1111, 1'b0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        n_vec++; if (lat != NB) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, NB); end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || sum !== exp[W-1:0] || cout !== exp[W] || parity !== ^exp[W-1:0]) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got ov=%b sum=%h c=%b p=%b want 1 %h %b %b",
                         k, out_valid, sum, cout, parity, exp[W-1:0], exp[W], ^exp[W-1:0]);
            end
        end
        drain();
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0)
                begin n_err++; $display("FAIL bp_single_handshake[%0d]: got ov=%b busy=%b want 0 0", k, out_valid, busy); end
            tick();
        end
    endtask

    task automatic test_ignored_in_valid();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   exp;
        int           lat;
        x = W'($urandom); y = W'($urandom);
        exp = ref_add(x, y, 1'b1);
        a = x; b = y; cin = 1'b1; in_valid = 1'b1;
        tick();
        a = W'(1); b = W'(1); cin = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50 && lat < 0; k++) begin
            tick();
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ign_in_ready_run[%0d]: got %b want 0", k, in_ready); end
            if (out_valid) lat = k;
        end
        n_vec++; if (lat != NB) begin n_err++; $display("FAIL ign_latency: got %0d want %0d", lat, NB); end
        tick();
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL ign_done: got ir=%b ov=%b want 0 1", in_ready, out_valid); end
        n_vec++; if (sum !== exp[W-1:0] || cout !== exp[W])
            begin n_err++; $display("FAIL ign_sum: got %h/%b want %h/%b", sum, cout, exp[W-1:0], exp[W]); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== exp[W-1:0])
            begin n_err++; $display("FAIL ign_no_restart: got busy=%b ov=%b sum=%h want 0 0 %h", busy, out_valid, sum, exp[W-1:0]); end
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] exp;
        int         lat;
        int         seen;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0)
            begin n_err++; $display("FAIL mid_rst_state: got ov=%b busy=%b sum=%h c=%b want 0 0 0 0", out_valid, busy, sum, cout); end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_rst_aborted: got %0d out_valid cycles want 0", seen); end
        exp = ref_add(32'h2, 32'h3, 1'b0);
        run_op(32'h2, 32'h3, 1'b0, lat);
        n_vec++; if (lat != NB) begin n_err++; $display("FAIL mid_rst_latency: got %0d want %0d", lat, NB); end
        n_vec++; if (sum !== exp[W-1:0] || parity !== ^exp[W-1:0])
            begin n_err++; $display("FAIL mid_rst_next_op: got %h/%b want %h/%b", sum, parity, exp[W-1:0], ^exp[W-1:0]); end
        drain();
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 30; i++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            if (i % 6 == 0) begin x = '1; y = '0; end
            if (i % 6 == 3) y = ~x;
            exp = ref_add(x, y, c);
            run_op(x, y, c, lat);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
            n_vec++;
            if (lat != NB || sum !== exp[W-1:0] || cout !== exp[W] || parity !== ^exp[W-1:0]) begin
                n_err++;
                $display("FAIL rnd[%0d] %h+%h+%b: got lat=%0d sum=%h c=%b p=%b want lat=%0d %h %b %b",
                         i, x, y, c, lat, sum, cout, parity, NB, exp[W-1:0], exp[W], ^exp[W-1:0]);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_directed(32'h0000_00FF, 32'h0000_0001, 1'b0);
        test_directed(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        test_backpressure();
        test_ignored_in_valid();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_multibyte_add_seq
`default_nettype wire
